taxi_qsfp_mgmt_ctrl: RTL and testbench

//  Sideband manager for PORT_CNT QSFP28 cages: sequences ResetL/LPMode per cage on insertion,
//  and arbitrates a single shared board-management I2C master among cages via ModSelL.

---
 rtl/taxi_qsfp_mgmt_pkg.sv | 26 ++
 rtl/taxi_qsfp_mgmt_ctrl_if.sv | 16 +
 rtl/taxi_qsfp_port_fsm.sv | 132 +++++++++++++
 rtl/taxi_qsfp_mgmt_ctrl.sv | 150 +++++++++++++++
 tb/tb_taxi_qsfp_mgmt_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/taxi_qsfp_mgmt_pkg.sv
// Shared types for the QSFP28 cage sideband manager.
//   port_state_t : per-cage insertion/reset sequencing state
//   arb_state_t  : shared board-management I2C arbiter state
//   cnt_last     : countdown terminal test; a load of N spends N cycles in
//                  the state (a load of 0 still spends one)
package taxi_qsfp_mgmt_pkg;

   typedef enum logic [1:0] {
      PS_ABSENT,
      PS_RESET,
      PS_INIT,
      PS_READY
   } port_state_t;

   typedef enum logic [1:0] {
      AS_IDLE,
      AS_SETUP,
      AS_GRANT,
      AS_HOLD
   } arb_state_t;

   function automatic logic cnt_last(input logic [31:0] c);
      return (c <= 32'd1);
   endfunction

endpackage

// File: rtl/taxi_qsfp_mgmt_ctrl_if.sv
// I2C access handshake between the cage manager and the core's shared I2C master.
//   i2c_req     : level request per cage (master -> manager)
//   i2c_gnt     : one-hot grant (manager -> master)
//   i2c_release : 1-cycle pulse, holder finished (master -> manager)
//   i2c_abort   : 1-cycle pulse, grant revoked because the cage left READY
interface taxi_qsfp_mgmt_ctrl_if #(
   parameter int unsigned PORT_CNT = 2
);
   logic [PORT_CNT-1:0] i2c_req;
   logic [PORT_CNT-1:0] i2c_gnt;
   logic                i2c_release;
   logic                i2c_abort;

   modport master (output i2c_req, output i2c_release, input i2c_gnt, input i2c_abort);
   modport slave  (input i2c_req, input i2c_release, output i2c_gnt, output i2c_abort);
endinterface

// File: rtl/taxi_qsfp_port_fsm.sv
// One QSFP cage: ModPrsL/IntL synchronizers, presence debounce and the
// ABSENT -> RESET -> INIT -> READY sequencer driving ResetL/LPMode.
//   modprsl_i/intl_i : raw cage pins (async)
//   rst_req_i        : 1-cycle soft reset request
//   cfg_lpmode_i     : LPMode requested while READY
//   resetl_o/lpmode_o: cage pins
//   present_o/ready_o/int_o : debounced presence, READY, masked interrupt
module taxi_qsfp_port_fsm
   import taxi_qsfp_mgmt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 1024,
   parameter int unsigned RESET_CYC    = 1250,
   parameter int unsigned INIT_CYC     = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic modprsl_i,
   input  logic intl_i,
   input  logic rst_req_i,
   input  logic cfg_lpmode_i,
   output logic resetl_o,
   output logic lpmode_o,
   output logic present_o,
   output logic ready_o,
   output logic int_o
);

   localparam int unsigned DB_LOAD = (DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0;
   localparam int unsigned DW      = (DB_LOAD < 1) ? 1 : $clog2(DB_LOAD + 1);
   localparam int unsigned CMAX    = (RESET_CYC > INIT_CYC) ? RESET_CYC : INIT_CYC;
   localparam int unsigned CW      = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

   logic prs_s1_q, prs_s2_q, int_s1_q, int_s2_q;
   logic present_q, present_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   port_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic lpmode_q;

   // Synchronizers idle at the pin-inactive level (absent, no interrupt)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prs_s1_q <= 1'b1;
         prs_s2_q <= 1'b1;
         int_s1_q <= 1'b1;
         int_s2_q <= 1'b1;
      end else begin
         prs_s1_q <= modprsl_i;
         prs_s2_q <= prs_s1_q;
         int_s1_q <= intl_i;
         int_s2_q <= int_s1_q;
      end
   end

   // Presence flips once DEBOUNCE_CYC consecutive samples disagree with it;
   // any agreeing sample reloads the counter.
   always_comb begin
      present_d = present_q;
      db_cnt_d  = DW'(DB_LOAD);
      if (~prs_s2_q != present_q) begin
         if (db_cnt_q == '0) present_d = ~prs_s2_q;
         else                db_cnt_d  = db_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         present_q <= 1'b0;
         db_cnt_q  <= DW'(DB_LOAD);
         state_q   <= PS_ABSENT;
         cnt_q     <= '0;
         lpmode_q  <= 1'b1;
      end else begin
         present_q <= present_d;
         db_cnt_q  <= db_cnt_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lpmode_q  <= cfg_lpmode_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!present_q) begin
         state_d = PS_ABSENT;
      end else begin
         unique case (state_q)
            PS_ABSENT: begin
               state_d = PS_RESET;
               cnt_d   = CW'(RESET_CYC);
            end
            PS_RESET: begin
               if (rst_req_i) begin
                  cnt_d = CW'(RESET_CYC);
               end else if (cnt_last(32'(cnt_q))) begin
                  state_d = PS_INIT;
                  cnt_d   = CW'(INIT_CYC);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            PS_INIT: begin
               if (rst_req_i) begin
                  state_d = PS_RESET;
                  cnt_d   = CW'(RESET_CYC);
               end else if (cnt_last(32'(cnt_q))) begin
                  state_d = PS_READY;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            PS_READY: begin
               if (rst_req_i) begin
                  state_d = PS_RESET;
                  cnt_d   = CW'(RESET_CYC);
               end
            end
            default: state_d = PS_ABSENT;
         endcase
      end
   end

   always_comb begin
      resetl_o  = (state_q == PS_INIT) || (state_q == PS_READY);
      ready_o   = (state_q == PS_READY);
      lpmode_o  = ready_o ? lpmode_q : 1'b1;
      present_o = present_q;
      int_o     = ~int_s2_q & ready_o;
   end

endmodule

// File: rtl/taxi_qsfp_mgmt_ctrl.sv
// Sideband manager for PORT_CNT QSFP28 cages: per-cage ResetL/LPMode
// sequencing and round-robin arbitration of one shared I2C master via ModSelL.
//   qsfp_* : cage pins      cfg_lpmode/port_rst_req : host controls
//   port_present/ready/int : per-cage status
//   i2c    : request/grant/release/abort handshake with the I2C master
module taxi_qsfp_mgmt_ctrl
   import taxi_qsfp_mgmt_pkg::*;
#(
   parameter int unsigned PORT_CNT     = 2,
   parameter int unsigned DEBOUNCE_CYC = 1024,
   parameter int unsigned RESET_CYC    = 1250,
   parameter int unsigned INIT_CYC     = 250000,
   parameter int unsigned MODSEL_SETUP = 250,
   parameter int unsigned MODSEL_HOLD  = 250
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PORT_CNT-1:0] qsfp_modprsl,
   input  logic [PORT_CNT-1:0] qsfp_intl,
   output logic [PORT_CNT-1:0] qsfp_resetl,
   output logic [PORT_CNT-1:0] qsfp_lpmode,
   output logic [PORT_CNT-1:0] qsfp_modsell,
   input  logic [PORT_CNT-1:0] cfg_lpmode,
   input  logic [PORT_CNT-1:0] port_rst_req,
   output logic [PORT_CNT-1:0] port_present,
   output logic [PORT_CNT-1:0] port_ready,
   output logic [PORT_CNT-1:0] port_int,
   taxi_qsfp_mgmt_ctrl_if.slave i2c
);

   localparam int unsigned IW   = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;
   localparam int unsigned AMAX = (MODSEL_SETUP > MODSEL_HOLD) ? MODSEL_SETUP : MODSEL_HOLD;
   localparam int unsigned AW   = (AMAX < 1) ? 1 : $clog2(AMAX + 1);

   for (genvar g = 0; g < PORT_CNT; g++) begin : g_port
      taxi_qsfp_port_fsm #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .RESET_CYC    (RESET_CYC),
         .INIT_CYC     (INIT_CYC)
      ) u_port (
         .clk          (clk),
         .rst_n        (rst_n),
         .modprsl_i    (qsfp_modprsl[g]),
         .intl_i       (qsfp_intl[g]),
         .rst_req_i    (port_rst_req[g]),
         .cfg_lpmode_i (cfg_lpmode[g]),
         .resetl_o     (qsfp_resetl[g]),
         .lpmode_o     (qsfp_lpmode[g]),
         .present_o    (port_present[g]),
         .ready_o      (port_ready[g]),
         .int_o        (port_int[g])
      );
   end

   arb_state_t arb_q, arb_d;
   logic [IW-1:0] sel_q, sel_d, rr_q, rr_d, pick;
   logic [AW-1:0] acnt_q, acnt_d;
   logic [PORT_CNT-1:0] eligible, gnt, modsell;
   logic pick_vld, sel_lost, abort;
   int unsigned idx;

   // First eligible cage at or after the round-robin pointer
   always_comb begin
      eligible = i2c.i2c_req & port_ready;
      pick_vld = 1'b0;
      pick     = '0;
      idx      = 0;
      for (int unsigned i = 0; i < PORT_CNT; i++) begin
         idx = (32'(rr_q) + i) % PORT_CNT;
         if (!pick_vld && eligible[idx]) begin
            pick_vld = 1'b1;
            pick     = IW'(idx);
         end
      end
   end

   assign sel_lost = !port_ready[sel_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_q  <= AS_IDLE;
         sel_q  <= '0;
         rr_q   <= '0;
         acnt_q <= '0;
      end else begin
         arb_q  <= arb_d;
         sel_q  <= sel_d;
         rr_q   <= rr_d;
         acnt_q <= acnt_d;
      end
   end

   // Losing the selected cage takes priority over release; both exit via HOLD
   // so ModSelL always gets its full hold time.
   always_comb begin
      arb_d  = arb_q;
      sel_d  = sel_q;
      rr_d   = rr_q;
      acnt_d = acnt_q;
      unique case (arb_q)
         AS_IDLE: begin
            if (pick_vld) begin
               arb_d  = AS_SETUP;
               sel_d  = pick;
               acnt_d = AW'(MODSEL_SETUP);
            end
         end
         AS_SETUP: begin
            if (sel_lost) begin
               arb_d  = AS_HOLD;
               acnt_d = AW'(MODSEL_HOLD);
            end else if (cnt_last(32'(acnt_q))) begin
               arb_d = AS_GRANT;
            end else begin
               acnt_d = acnt_q - 1'b1;
            end
         end
         AS_GRANT: begin
            if (sel_lost || i2c.i2c_release) begin
               arb_d  = AS_HOLD;
               acnt_d = AW'(MODSEL_HOLD);
            end
         end
         AS_HOLD: begin
            if (cnt_last(32'(acnt_q))) begin
               arb_d = AS_IDLE;
               rr_d  = (32'(sel_q) == PORT_CNT - 1) ? '0 : sel_q + 1'b1;
            end else begin
               acnt_d = acnt_q - 1'b1;
            end
         end
         default: arb_d = AS_IDLE;
      endcase
   end

   // Grant is masked by the cage's READY so it drops in the same cycle abort pulses
   always_comb begin
      modsell = '1;
      gnt     = '0;
      abort   = 1'b0;
      if (arb_q != AS_IDLE) modsell[sel_q] = 1'b0;
      if (arb_q == AS_GRANT && !sel_lost) gnt[sel_q] = 1'b1;
      if ((arb_q == AS_SETUP || arb_q == AS_GRANT) && sel_lost) abort = 1'b1;
   end

   assign qsfp_modsell  = modsell;
   assign i2c.i2c_gnt   = gnt;
   assign i2c.i2c_abort = abort;

endmodule

// File: tb/tb_taxi_qsfp_mgmt_ctrl.sv
module tb_taxi_qsfp_mgmt_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] modprsl, intl, cfg, rst_req;
   logic [1:0] resetl, lpmode, modsell, present, ready, pint;

   always #5 clk = ~clk;

   taxi_qsfp_mgmt_ctrl_if #(.PORT_CNT(2)) i2c_if ();

   taxi_qsfp_mgmt_ctrl #(
      .PORT_CNT     (2),
      .DEBOUNCE_CYC (4),
      .RESET_CYC    (10),
      .INIT_CYC     (20),
      .MODSEL_SETUP (5),
      .MODSEL_HOLD  (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .qsfp_modprsl (modprsl),
      .qsfp_intl    (intl),
      .qsfp_resetl  (resetl),
      .qsfp_lpmode  (lpmode),
      .qsfp_modsell (modsell),
      .cfg_lpmode   (cfg),
      .port_rst_req (rst_req),
      .port_present (present),
      .port_ready   (ready),
      .port_int     (pint),
      .i2c          (i2c_if)
   );

   typedef struct {
      logic [1:0] cfg;
      logic [1:0] intl;
      logic [1:0] exp_lp;
      logic [1:0] exp_int;
   } vec_t;

   vec_t vecs [4];
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n;
      logic seen;

      vecs[0] = '{cfg: 2'b00, intl: 2'b11, exp_lp: 2'b00, exp_int: 2'b00};
      vecs[1] = '{cfg: 2'b01, intl: 2'b10, exp_lp: 2'b01, exp_int: 2'b01};
      vecs[2] = '{cfg: 2'b10, intl: 2'b01, exp_lp: 2'b10, exp_int: 2'b10};
      vecs[3] = '{cfg: 2'b11, intl: 2'b00, exp_lp: 2'b11, exp_int: 2'b11};

      rst_n = 1'b0;
      modprsl = 2'b11;
      intl = 2'b11;
      cfg = 2'b00;
      rst_req = 2'b00;
      i2c_if.i2c_req = 2'b00;
      i2c_if.i2c_release = 1'b0;
      step();
      step();
      chk("rst_resetl", 32'(resetl), 32'h0);
      chk("rst_lpmode", 32'(lpmode), 32'h3);
      chk("rst_modsell", 32'(modsell), 32'h3);
      chk("rst_gnt", 32'(i2c_if.i2c_gnt), 32'h0);
      chk("rst_status", {26'd0, present, ready, pint}, 32'h0);
      chk("rst_abort", 32'(i2c_if.i2c_abort), 32'h0);
      rst_n = 1'b1;
      step();

      // 3-cycle glitch on cage0 presence must be rejected
      modprsl = 2'b10;
      repeat (3) step();
      modprsl = 2'b11;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (present[0] || resetl[0]) seen = 1'b1;
      end
      chk("glitch_ignored", 32'(seen), 32'h0);

      // Insert both cages; cage0 timing is measured exactly
      modprsl = 2'b00;
      n = 0;
      while (!present[0] && n < 40) begin step(); n++; end
      chk("present_latency", n, 6);
      chk("resetl_low_at_present", 32'(resetl), 32'h0);
      n = 0;
      while (!resetl[0] && n < 40) begin step(); n++; end
      chk("resetl_release", n, 11);
      chk("lpmode_in_init", 32'(lpmode), 32'h3);
      n = 0;
      while (!ready[0] && n < 60) begin step(); n++; end
      chk("ready_latency", n, 20);
      chk("both_ready", 32'(ready), 32'h3);

      // LPMode follows cfg, interrupt is synchronized ~IntL while READY
      for (int v = 0; v < 4; v++) begin
         cfg = vecs[v].cfg;
         intl = vecs[v].intl;
         step();
         step();
         chk($sformatf("vec%0d_lpmode", v), 32'(lpmode), 32'(vecs[v].exp_lp));
         chk($sformatf("vec%0d_int", v), 32'(pint), 32'(vecs[v].exp_int));
      end
      cfg = 2'b00;
      intl = 2'b11;
      step();
      step();

      // Both request: cage0 first (rr ptr 0)
      i2c_if.i2c_req = 2'b11;
      step();
      chk("setup0_modsell", 32'(modsell), 32'h2);
      chk("setup0_gnt", 32'(i2c_if.i2c_gnt), 32'h0);
      n = 0;
      while (i2c_if.i2c_gnt == 2'b00 && n < 20) begin step(); n++; end
      chk("setup0_len", n, 5);
      chk("gnt0", 32'(i2c_if.i2c_gnt), 32'h1);
      step();
      step();
      chk("gnt0_held", 32'(i2c_if.i2c_gnt), 32'h1);
      i2c_if.i2c_release = 1'b1;
      step();
      i2c_if.i2c_release = 1'b0;
      chk("hold0_gnt", 32'(i2c_if.i2c_gnt), 32'h0);
      chk("hold0_modsell_a", 32'(modsell), 32'h2);
      step();
      step();
      chk("hold0_modsell_c", 32'(modsell), 32'h2);
      step();
      chk("idle_modsell", 32'(modsell), 32'h3);
      step();
      chk("setup1_modsell", 32'(modsell), 32'h1);
      // Release outside GRANT must not disturb the setup
      i2c_if.i2c_release = 1'b1;
      step();
      i2c_if.i2c_release = 1'b0;
      n = 1;
      while (i2c_if.i2c_gnt == 2'b00 && n < 20) begin step(); n++; end
      chk("setup1_len", n, 5);
      chk("gnt1", 32'(i2c_if.i2c_gnt), 32'h2);

      // Pull cage1 during its grant
      modprsl = 2'b10;
      n = 0;
      while (!i2c_if.i2c_abort && n < 20) begin step(); n++; end
      chk("abort_latency", n, 7);
      chk("abort_gnt", 32'(i2c_if.i2c_gnt), 32'h0);
      chk("abort_ready1", 32'(ready[1]), 32'h0);
      chk("abort_resetl1", 32'(resetl[1]), 32'h0);
      step();
      chk("abort_pulse_once", 32'(i2c_if.i2c_abort), 32'h0);
      chk("abort_hold_a", 32'(modsell), 32'h1);
      step();
      step();
      chk("abort_hold_c", 32'(modsell), 32'h1);
      step();
      chk("abort_idle", 32'(modsell), 32'h3);
      i2c_if.i2c_req = 2'b00;

      // Soft reset of ready cage0; request to absent cage1 is ignored
      rst_req = 2'b11;
      step();
      rst_req = 2'b00;
      chk("srst_ready0", 32'(ready[0]), 32'h0);
      chk("srst_resetl", 32'(resetl), 32'h0);
      chk("srst_lpmode0", 32'(lpmode[0]), 32'h1);
      n = 0;
      while (!resetl[0] && n < 40) begin step(); n++; end
      chk("srst_reset_len", n, 10);
      n = 0;
      while (!ready[0] && n < 60) begin step(); n++; end
      chk("srst_init_len", n, 20);
      chk("absent1_stays", {30'd0, resetl[1], ready[1]}, 32'h0);
      chk("srst_lpmode_cfg0", 32'(lpmode[0]), 32'h0);
      cfg = 2'b01;
      step();
      chk("srst_lpmode_cfg1", 32'(lpmode[0]), 32'h1);

      // Async reset in the middle of a grant
      i2c_if.i2c_req = 2'b01;
      n = 0;
      while (i2c_if.i2c_gnt == 2'b00 && n < 20) begin step(); n++; end
      chk("pre_areset_gnt", 32'(i2c_if.i2c_gnt), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_modsell", 32'(modsell), 32'h3);
      chk("areset_gnt", 32'(i2c_if.i2c_gnt), 32'h0);
      chk("areset_resetl_lpmode", {28'd0, resetl, lpmode}, 32'h3);
      chk("areset_status", {25'd0, present, ready, pint, i2c_if.i2c_abort}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
